// File: rtl/i2s_pcm_receiver.sv
// I2S stereo deserializer: oversamples bclk/lrclk/sdata in the master clock domain
// and emits 24-bit left/right PCM words with one-clock valid strobes.
module i2s_pcm_receiver #(
  parameter int DataBits   = 24,
  parameter int SyncStages = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i2s_bclk,
  input  logic                i2s_lrclk,
  input  logic                i2s_sdata,
  output logic                l_pcm_valid,
  output logic                r_pcm_valid,
  output logic [DataBits-1:0] l_pcm_data,
  output logic [DataBits-1:0] r_pcm_data,
  output logic                frame_err,
  output logic                locked
);

  localparam int CntW = $clog2(DataBits + 1);

  typedef enum logic [1:0] {WAIT_LR = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  logic [SyncStages-1:0] bclk_sync_r, lr_sync_r, sd_sync_r;
  logic                  bclk_q_r, lr_prev_r;
  logic                  bclk_s, lr_s, sd_s, bclk_rise_s, lr_change_s;

  state_t                state_r, state_nxt_s;
  logic [DataBits-1:0]   shift_r, shift_nxt_s;
  logic [CntW-1:0]       bit_cnt_r, bit_cnt_nxt_s;
  logic                  chan_r, chan_nxt_s;
  logic                  locked_r, locked_nxt_s;
  logic                  frame_err_r, frame_err_nxt_s;
  logic                  word_done_r, word_done_nxt_s;

  logic                  l_valid_r, r_valid_r;
  logic [DataBits-1:0]   l_data_r, r_data_r;

  // Pin synchronizers, bclk edge detector and word-select history.
  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_r <= {SyncStages{1'b0}};
      lr_sync_r   <= {SyncStages{1'b0}};
      sd_sync_r   <= {SyncStages{1'b0}};
      bclk_q_r    <= 1'b0;
      lr_prev_r   <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SyncStages-2:0], i2s_bclk};
      lr_sync_r   <= {lr_sync_r[SyncStages-2:0], i2s_lrclk};
      sd_sync_r   <= {sd_sync_r[SyncStages-2:0], i2s_sdata};
      bclk_q_r    <= bclk_s;
      if (bclk_rise_s) begin
        lr_prev_r <= lr_s;
      end
    end
  end

  assign bclk_s      = bclk_sync_r[SyncStages-1];
  assign lr_s        = lr_sync_r[SyncStages-1];
  assign sd_s        = sd_sync_r[SyncStages-1];
  assign bclk_rise_s = bclk_s & ~bclk_q_r;
  assign lr_change_s = bclk_rise_s & (lr_s != lr_prev_r);

  // Slot framing FSM: all decisions are taken on a bclk rising edge.
  always_comb begin
    state_nxt_s     = state_r;
    shift_nxt_s     = shift_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    chan_nxt_s      = chan_r;
    locked_nxt_s    = locked_r;
    frame_err_nxt_s = 1'b0;
    word_done_nxt_s = 1'b0;
    if (bclk_rise_s) begin
      case (state_r)
        WAIT_LR: begin
          if (lr_change_s) begin
            chan_nxt_s    = lr_s;
            bit_cnt_nxt_s = {CntW{1'b0}};
            locked_nxt_s  = 1'b1;
            state_nxt_s   = SHIFT;
          end else begin
            state_nxt_s = WAIT_LR;
          end
        end
        SHIFT: begin
          // The edge that shows the new word select still carries the old slot's LSB.
          if (lr_change_s) begin
            frame_err_nxt_s = (bit_cnt_r != {CntW{1'b0}});
            chan_nxt_s      = lr_s;
            bit_cnt_nxt_s   = {CntW{1'b0}};
            state_nxt_s     = SHIFT;
          end else begin
            shift_nxt_s   = {shift_r[DataBits-2:0], sd_s};
            bit_cnt_nxt_s = bit_cnt_r + {{(CntW-1){1'b0}}, 1'b1};
            if (bit_cnt_r == CntW'(DataBits - 1)) begin
              word_done_nxt_s = 1'b1;
              state_nxt_s     = DONE;
            end else begin
              state_nxt_s = SHIFT;
            end
          end
        end
        DONE: begin
          if (lr_change_s) begin
            chan_nxt_s    = lr_s;
            bit_cnt_nxt_s = {CntW{1'b0}};
            state_nxt_s   = SHIFT;
          end else begin
            state_nxt_s = DONE;
          end
        end
        default: begin
          state_nxt_s = WAIT_LR;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= WAIT_LR;
      shift_r     <= {DataBits{1'b0}};
      bit_cnt_r   <= {CntW{1'b0}};
      chan_r      <= 1'b0;
      locked_r    <= 1'b0;
      frame_err_r <= 1'b0;
      word_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      shift_r     <= shift_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      chan_r      <= chan_nxt_s;
      locked_r    <= locked_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      word_done_r <= word_done_nxt_s;
    end
  end

  // Output word registers, loaded the clock after a word completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      l_valid_r <= 1'b0;
      r_valid_r <= 1'b0;
      l_data_r  <= {DataBits{1'b0}};
      r_data_r  <= {DataBits{1'b0}};
    end else begin
      l_valid_r <= word_done_r & ~chan_r;
      r_valid_r <= word_done_r & chan_r;
      if (word_done_r & ~chan_r) begin
        l_data_r <= shift_r;
      end
      if (word_done_r & chan_r) begin
        r_data_r <= shift_r;
      end
    end
  end

  assign l_pcm_valid = l_valid_r;
  assign r_pcm_valid = r_valid_r;
  assign l_pcm_data  = l_data_r;
  assign r_pcm_data  = r_data_r;
  assign frame_err   = frame_err_r;
  assign locked      = locked_r;

endmodule

// File: tb/tb_i2s_pcm_receiver.sv
// Directed bench for i2s_pcm_receiver: drives I2S slots at bclk = clk/4 and checks
// captured words, framing errors, lock, latency and reset behaviour.
module tb_i2s_pcm_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i2s_bclk = 1'b0, i2s_lrclk = 1'b0, i2s_sdata = 1'b0;
  logic        l_pcm_valid, r_pcm_valid, frame_err, locked;
  logic [23:0] l_pcm_data, r_pcm_data;

  int          vec_cnt = 0, err_cnt = 0;
  int          cyc = 0, rise_cyc = 0, strobe_cyc = -1;
  int          ferr_cnt = 0, both_cnt = 0, glitch_cnt = 0;
  logic        mask_glitch = 1'b1;
  logic        last_bit = 1'b0;
  logic [23:0] l_prev = 24'd0, r_prev = 24'd0;
  logic [24:0] strobe_q[$];
  logic [24:0] exp_word;

  i2s_pcm_receiver #(.DataBits(24), .SyncStages(2)) dut (
    .clk(clk), .reset(reset),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_sdata(i2s_sdata),
    .l_pcm_valid(l_pcm_valid), .r_pcm_valid(r_pcm_valid),
    .l_pcm_data(l_pcm_data), .r_pcm_data(r_pcm_data),
    .frame_err(frame_err), .locked(locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe/error logger, sampled on the falling clock edge.
  initial begin
    forever begin
      @(negedge clk);
      if (l_pcm_valid) strobe_q.push_back({1'b0, l_pcm_data});
      if (r_pcm_valid) strobe_q.push_back({1'b1, r_pcm_data});
      if (l_pcm_valid || r_pcm_valid) strobe_cyc = cyc;
      if (l_pcm_valid && r_pcm_valid) both_cnt++;
      if (frame_err) ferr_cnt++;
      if (!mask_glitch && !l_pcm_valid && l_pcm_data != l_prev) glitch_cnt++;
      if (!mask_glitch && !r_pcm_valid && r_pcm_data != r_prev) glitch_cnt++;
      l_prev = l_pcm_data;
      r_prev = r_pcm_data;
    end
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bclk_period(input logic lr, input logic sd, input logic meas);
    @(negedge clk);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_sdata = sd;
    @(negedge clk);
    @(negedge clk);
    i2s_bclk = 1'b1;
    if (meas) rise_cyc = cyc;
    @(negedge clk);
  endtask

  // One lrclk phase of len bclk periods; data lags word select by one bit.
  task automatic send_slot(input logic lr, input logic [23:0] word, input int len, input logic meas);
    logic b;
    b = last_bit;
    for (int j = 0; j < len; j++) begin
      if (j == 0) b = last_bit;
      else if (j <= 24) b = word[24-j];
      else b = 1'b1;
      bclk_period(lr, b, meas && (j == 24));
    end
    last_bit = b;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_vec({tag, "_lvalid"}, 32'(l_pcm_valid), 32'd0);
    check_vec({tag, "_rvalid"}, 32'(r_pcm_valid), 32'd0);
    check_vec({tag, "_ldata"},  32'(l_pcm_data),  32'd0);
    check_vec({tag, "_rdata"},  32'(r_pcm_data),  32'd0);
    check_vec({tag, "_ferr"},   32'(frame_err),   32'd0);
    check_vec({tag, "_locked"}, 32'(locked),      32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("rst");
    @(negedge clk);
    mask_glitch = 1'b0;

    // Partial first slot, then 32-bit slots with trailing 1s.
    send_slot(1'b0, 24'hFFFFFF, 10, 1'b0);
    check_vec("t1_partial_strobes", 32'(strobe_q.size()), 32'd0);
    check_vec("t1_partial_locked", 32'(locked), 32'd0);
    send_slot(1'b1, 24'h654321, 32, 1'b0);
    send_slot(1'b0, 24'hA5F00F, 32, 1'b0);
    send_slot(1'b1, 24'h123456, 32, 1'b0);
    check_vec("t1_strobes", 32'(strobe_q.size()), 32'd3);
    check_vec("t1_word0", 32'(strobe_q[0]), 32'h1654321);
    check_vec("t1_word1", 32'(strobe_q[1]), 32'h0A5F00F);
    check_vec("t1_word2", 32'(strobe_q[2]), 32'h1123456);
    check_vec("t1_locked", 32'(locked), 32'd1);
    check_vec("t1_ferr", 32'(ferr_cnt), 32'd0);
    strobe_q.delete();

    // Tight slots: exactly 24 data bits after the word-select edge.
    for (int f = 0; f < 4; f++) begin
      send_slot(1'b0, 24'h800000, 25, 1'b0);
      send_slot(1'b1, 24'h7FFFFF, 25, 1'b0);
    end
    repeat (6) @(negedge clk);
    check_vec("t2_strobes", 32'(strobe_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      exp_word = (i % 2 == 0) ? 25'h0800000 : 25'h17FFFFF;
      check_vec("t2_word", 32'(strobe_q[i]), 32'(exp_word));
    end
    check_vec("t2_ferr", 32'(ferr_cnt), 32'd0);
    strobe_q.delete();

    // Short left slot of 20 bits, then a normal right word.
    send_slot(1'b0, 24'hABCDEF, 21, 1'b0);
    send_slot(1'b1, 24'h00FF00, 25, 1'b0);
    repeat (6) @(negedge clk);
    check_vec("t3_ferr", 32'(ferr_cnt), 32'd1);
    check_vec("t3_strobes", 32'(strobe_q.size()), 32'd1);
    check_vec("t3_rword", 32'(strobe_q[0]), 32'h100FF00);
    check_vec("t3_lhold", 32'(l_pcm_data), 32'h800000);
    strobe_q.delete();

    // Latency from the 24th bit's pin rising edge to the strobe.
    send_slot(1'b0, 24'h3C3C3C, 25, 1'b1);
    repeat (4) @(negedge clk);
    check_vec("t4_latency", 32'(strobe_cyc - rise_cyc), 32'd4);
    check_vec("t4_strobes", 32'(strobe_q.size()), 32'd1);
    check_vec("t4_word", 32'(strobe_q[0]), 32'h03C3C3C);
    strobe_q.delete();

    // Reset after 12 bits of a left word.
    send_slot(1'b1, 24'h111111, 25, 1'b0);
    send_slot(1'b0, 24'h5A5A5A, 13, 1'b0);
    check_vec("t5_pre_strobes", 32'(strobe_q.size()), 32'd1);
    check_vec("t5_pre_word", 32'(strobe_q[0]), 32'h1111111);
    strobe_q.delete();
    mask_glitch = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_outputs_zero("t5_rst");
    @(negedge clk);
    mask_glitch = 1'b0;
    send_slot(1'b0, 24'h000000, 12, 1'b0);
    check_vec("t5_no_strobe", 32'(strobe_q.size()), 32'd0);
    check_vec("t5_unlocked", 32'(locked), 32'd0);
    send_slot(1'b1, 24'h5A5A5A, 25, 1'b0);
    repeat (6) @(negedge clk);
    check_vec("t5_strobes", 32'(strobe_q.size()), 32'd1);
    check_vec("t5_word", 32'(strobe_q[0]), 32'h15A5A5A);
    check_vec("t5_locked", 32'(locked), 32'd1);
    check_vec("t5_ferr", 32'(ferr_cnt), 32'd1);
    strobe_q.delete();

    // Idle bclk while lrclk toggles, then resume normally.
    i2s_bclk = 1'b0;
    for (int k = 0; k < 5; k++) begin
      repeat (3) @(negedge clk);
      i2s_lrclk = ~i2s_lrclk;
    end
    repeat (6) @(negedge clk);
    check_vec("t6_idle_strobes", 32'(strobe_q.size()), 32'd0);
    check_vec("t6_idle_ferr", 32'(ferr_cnt), 32'd1);
    check_vec("t6_idle_locked", 32'(locked), 32'd1);
    send_slot(1'b0, 24'h0F0F0F, 25, 1'b0);
    repeat (6) @(negedge clk);
    check_vec("t6_strobes", 32'(strobe_q.size()), 32'd1);
    check_vec("t6_word", 32'(strobe_q[0]), 32'h00F0F0F);
    check_vec("t6_ferr", 32'(ferr_cnt), 32'd1);

    check_vec("both_valid", 32'(both_cnt), 32'd0);
    check_vec("data_glitch", 32'(glitch_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
